// File: rtl/spi_byte_sequencer.sv
// rtl/spi_byte_sequencer.sv - TX/RX byte FIFOs and sequencing FSM feeding an SPI byte engine
// Drives the engine one byte at a time and manages the active-low slave select.

module spi_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int PW    = 2,
  parameter int LW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic [LW-1:0] level_o
);
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Callers qualify push/pop; a push while full is only issued alongside a pop.
  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push_i && !pop_i) begin
      level_d = level_q + LW'(1);
    end else if (pop_i && !push_i) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
endmodule

module spi_byte_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     tx_full,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   tx_level,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     rx_ovf,
  input  logic                     ovf_clr,
  input  logic                     cs_auto,
  input  logic                     cs_manual,
  output logic                     active,
  output logic                     spi_ssel_n,
  output logic [7:0]               eng_txdata,
  output logic                     eng_txstart,
  input  logic [7:0]               eng_rxdata,
  input  logic                     eng_busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_CAPTURE
  } state_t;

  state_t     state_q, state_d;
  logic       ssel_n_q, ssel_n_d;
  logic [7:0] txdata_q, txdata_d;
  logic       ovf_q, ovf_d;
  logic [7:0] tx_head;
  logic       tx_push, tx_pop, rx_push, rx_pop, rx_full, capture, drop;

  spi_seq_fifo #(.DEPTH(DEPTH), .PW(PW), .LW(LW)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .din_i   (wr_data),
    .dout_o  (tx_head),
    .level_o (tx_level)
  );

  spi_seq_fifo #(.DEPTH(DEPTH), .PW(PW), .LW(LW)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .din_i   (eng_rxdata),
    .dout_o  (rd_data),
    .level_o (rx_level)
  );

  assign tx_full  = (tx_level == FULL_LVL);
  assign rx_full  = (rx_level == FULL_LVL);
  assign rx_empty = (rx_level == '0);
  assign tx_push  = wr_en && !tx_full;
  assign rx_pop   = rd_en && !rx_empty;
  // A CPU read in the capture cycle frees the slot the captured byte needs.
  assign rx_push  = capture && (!rx_full || rx_pop);
  assign drop     = capture && rx_full && !rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (tx_level != '0) begin
          state_d = (cs_auto && ssel_n_q) ? S_SETUP : S_START;
        end
      end
      S_SETUP:   state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT:    if (!eng_busy) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eng_txstart = 1'b0;
    tx_pop      = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      S_START: begin
        eng_txstart = 1'b1;
        tx_pop      = 1'b1;
      end
      S_CAPTURE: capture = 1'b1;
      default: ;
    endcase
  end

  // The byte is latched on entry to START so it is stable alongside the start pulse.
  always_comb begin
    txdata_d = (state_d == S_START && state_q != S_START) ? tx_head : txdata_q;
    ssel_n_d = !(cs_manual || (cs_auto && (state_q != S_IDLE || tx_level != '0)));
    ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssel_n_q <= 1'b1;
      txdata_q <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      ssel_n_q <= ssel_n_d;
      txdata_q <= txdata_d;
      ovf_q    <= ovf_d;
    end
  end

  assign spi_ssel_n = ssel_n_q;
  assign eng_txdata = txdata_q;
  assign rx_ovf     = ovf_q;
  assign active     = (tx_level != '0) || (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_byte_sequencer.sv
// tb/tb_spi_byte_sequencer.sv - self-checking bench for spi_byte_sequencer with a loopback engine model
module tb_spi_byte_sequencer;
  localparam int DEPTH = 4;
  localparam int LW    = 3;
  localparam int LEN   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_en = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
  logic          cs_auto = 1'b0, cs_manual = 1'b0;
  logic [7:0]    rd_data, eng_txdata;
  logic          tx_full, rx_empty, rx_ovf, active, spi_ssel_n, eng_txstart;
  logic [LW-1:0] tx_level, rx_level;
  logic [7:0]    eng_rxdata;
  logic          eng_busy;

  spi_byte_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
    .rd_data(rd_data), .tx_full(tx_full), .rx_empty(rx_empty), .tx_level(tx_level),
    .rx_level(rx_level), .rx_ovf(rx_ovf), .ovf_clr(ovf_clr), .cs_auto(cs_auto),
    .cs_manual(cs_manual), .active(active), .spi_ssel_n(spi_ssel_n),
    .eng_txdata(eng_txdata), .eng_txstart(eng_txstart), .eng_rxdata(eng_rxdata),
    .eng_busy(eng_busy)
  );

  always #5 clk = ~clk;

  int         vec = 0;
  int         errs = 0;
  int         n_starts = 0;
  logic       ssel_at_start = 1'b1;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic       stall = 1'b0;
  logic [7:0] eng_sh;
  int         eng_cnt;

  // Loopback engine: busy rises after txstart, holds LEN cycles (longer while stalled).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy   <= 1'b0;
      eng_rxdata <= 8'h00;
      eng_sh     <= 8'h00;
      eng_cnt    <= 0;
    end else if (eng_txstart) begin
      eng_busy <= 1'b1;
      eng_sh   <= eng_txdata;
      eng_cnt  <= LEN - 1;
    end else if (eng_busy && eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_busy && !stall) begin
      eng_busy   <= 1'b0;
      eng_rxdata <= eng_sh;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && eng_txstart) begin
      chk("start_while_busy", eng_busy, 0);
      if (tx_exp.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        chk("txdata_order", eng_txdata, tx_exp.pop_front());
      end
      rx_exp.push_back(eng_txdata);
      ssel_at_start = spi_ssel_n;
      n_starts++;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accepted);
    wr_data = b;
    wr_en   = 1'b1;
    if (accepted) tx_exp.push_back(b);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (active !== 1'b0 && t < 500) begin
      cyc();
      t++;
    end
    if (t >= 500) chk(name, 1, 0);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int t = 0;
    while (eng_busy !== lvl && t < 500) begin
      cyc();
      t++;
    end
    if (t >= 500) chk(name, 1, 0);
  endtask

  task automatic read_expect(input logic [7:0] b, input string name);
    chk(name, rd_data, b);
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       cs_auto;
    logic       cs_manual;
    logic       exp_ssel;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int s0, highs, sent, acc, pops_done, lvl_err, got, t;
    logic [7:0] e;
    tbl[0] = '{8'h11, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[1] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h22};
    tbl[2] = '{8'h33, 1'b0, 1'b1, 1'b0, 8'h33};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF};

    #2 rst_n = 1'b0;
    cyc();
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_ovf", rx_ovf, 0);
    chk("rst_active", active, 0);
    chk("rst_ssel_n", spi_ssel_n, 1);
    chk("rst_txstart", eng_txstart, 0);
    chk("rst_txdata", eng_txdata, 0);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 5; i++) begin
      cs_auto   = tbl[i].cs_auto;
      cs_manual = tbl[i].cs_manual;
      write_byte(tbl[i].data, 1'b1);
      wait_idle($sformatf("row%0d_timeout", i));
      chk($sformatf("row%0d_ssel_at_start", i), ssel_at_start, tbl[i].exp_ssel);
      chk($sformatf("row%0d_rx_level", i), rx_level, 1);
      read_expect(tbl[i].exp_rx, $sformatf("row%0d_rd_data", i));
      chk($sformatf("row%0d_rx_empty", i), rx_empty, 1);
      cs_auto   = 1'b0;
      cs_manual = 1'b0;
      cyc();
      cyc();
    end

    // Burst with automatic select
    cs_auto = 1'b1;
    s0 = n_starts;
    write_byte(8'hA5, 1'b1);
    chk("burst_ssel_before_setup", spi_ssel_n, 1);
    write_byte(8'h3C, 1'b1);
    write_byte(8'hFF, 1'b1);
    highs = 0;
    t = 0;
    while (active === 1'b1 && t < 500) begin
      if (spi_ssel_n !== 1'b0) highs++;
      cyc();
      t++;
    end
    if (t >= 500) chk("burst_timeout", 1, 0);
    chk("burst_ssel_low", highs, 0);
    chk("burst_starts", n_starts - s0, 3);
    chk("burst_ssel_hold_idle", spi_ssel_n, 0);
    cyc();
    chk("burst_ssel_release", spi_ssel_n, 1);
    chk("burst_rx_level", rx_level, 3);
    read_expect(8'hA5, "burst_rx0");
    read_expect(8'h3C, "burst_rx1");
    read_expect(8'hFF, "burst_rx2");
    cs_auto = 1'b0;
    cyc();

    // TX full with engine stalled, then RX overflow on the five resulting transfers
    stall = 1'b1;
    s0 = n_starts;
    write_byte(8'h90, 1'b1);
    wait_busy(1'b1, "full_busy_timeout");
    for (int i = 0; i < 6; i++) write_byte(8'h61 + 8'(i), i < 4);
    chk("full_tx_level", tx_level, 4);
    chk("full_tx_full", tx_full, 1);
    stall = 1'b0;
    wait_idle("full_timeout");
    chk("full_starts", n_starts - s0, 5);
    chk("ovf_rx_level", rx_level, 4);
    chk("ovf_set", rx_ovf, 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_cleared", rx_ovf, 0);
    read_expect(8'h90, "ovf_rx0");
    read_expect(8'h61, "ovf_rx1");
    read_expect(8'h62, "ovf_rx2");
    read_expect(8'h63, "ovf_rx3");
    chk("ovf_rx_drained", rx_empty, 1);

    // Read during CAPTURE with RX full must not drop
    for (int i = 0; i < 4; i++) begin
      write_byte(8'hC0 + 8'(i), 1'b1);
      wait_idle("cap_fill_timeout");
    end
    chk("cap_rx_full", rx_level, 4);
    write_byte(8'hC4, 1'b1);
    wait_busy(1'b1, "cap_busy_timeout");
    wait_busy(1'b0, "cap_done_timeout");
    cyc();
    read_expect(8'hC0, "cap_head");
    chk("cap_rx_level", rx_level, 4);
    chk("cap_no_ovf", rx_ovf, 0);
    wait_idle("cap_timeout");
    for (int i = 1; i < 5; i++) read_expect(8'hC0 + 8'(i), $sformatf("cap_rx%0d", i));

    // Manual select with nothing queued
    cs_manual = 1'b1;
    s0 = n_starts;
    cyc();
    cyc();
    cyc();
    chk("manual_ssel", spi_ssel_n, 0);
    chk("manual_active", active, 0);
    chk("manual_no_start", n_starts - s0, 0);
    cs_manual = 1'b0;
    cyc();
    cyc();
    chk("manual_release", spi_ssel_n, 1);

    // Streaming with concurrent writes and reads across pointer wrap
    rx_exp.delete();
    cs_auto = 1'b1;
    s0 = n_starts;
    sent = 0;
    acc = 0;
    got = 0;
    lvl_err = 0;
    t = 0;
    while ((sent < 12 || active === 1'b1 || rx_empty === 1'b0) && t < 3000) begin
      pops_done = (n_starts - s0) - (eng_txstart ? 1 : 0);
      if (tx_level !== LW'(acc - pops_done)) lvl_err++;
      if (rx_empty === 1'b0) begin
        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 8'hxx;
        chk($sformatf("stream_rx%0d", got), rd_data, e);
        rd_en = 1'b1;
        got++;
      end else begin
        rd_en = 1'b0;
      end
      if (sent < 12 && tx_full === 1'b0) begin
        wr_data = 8'h30 + 8'(sent);
        wr_en = 1'b1;
        tx_exp.push_back(wr_data);
        sent++;
        acc++;
      end else begin
        wr_en = 1'b0;
      end
      cyc();
      t++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (t >= 3000) chk("stream_timeout", 1, 0);
    chk("stream_tx_level_track", lvl_err, 0);
    chk("stream_rx_count", got, 12);
    chk("stream_starts", n_starts - s0, 12);
    chk("stream_tx_exp_drained", tx_exp.size(), 0);
    cs_auto = 1'b0;
    cyc();
    cyc();

    // Reset while waiting on a stalled engine
    cs_auto = 1'b1;
    stall = 1'b1;
    write_byte(8'hE7, 1'b1);
    wait_busy(1'b1, "rstw_busy_timeout");
    chk("rstw_pre_ssel", spi_ssel_n, 0);
    rst_n = 1'b0;
    #1;
    chk("rstw_active", active, 0);
    chk("rstw_ssel_n", spi_ssel_n, 1);
    chk("rstw_txstart", eng_txstart, 0);
    chk("rstw_txdata", eng_txdata, 0);
    chk("rstw_tx_level", tx_level, 0);
    chk("rstw_rx_empty", rx_empty, 1);
    chk("rstw_rx_ovf", rx_ovf, 0);
    tx_exp.delete();
    stall = 1'b0;
    cs_auto = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
